// File: rtl/order_book_sched.sv
// order_book_sched: two-queue (add / delete-execute) round-robin issue scheduler feeding an order book.
// Ports: clkIn/rstNIn (sync active-low); add*/del* valid-ready request channels with payload;
// addValidOut/delExecValidOut one-cycle issue strobes with held field outputs; busyOut.
// Optional ORDER_BOOK_SCHED_STATS_EN adds issueCntOut/stallCntOut counters.
module order_book_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 4
) (
    input  logic        clkIn,
    input  logic        rstNIn,
    input  logic        addValidIn,
    output logic        addReadyOut,
    input  logic [15:0] addLocateIn,
    input  logic [31:0] addPriceIn,
    input  logic [31:0] addSharesIn,
    input  logic        addBuySellIn,
    input  logic        delValidIn,
    output logic        delReadyOut,
    input  logic [15:0] delLocateIn,
    input  logic [31:0] delPriceIn,
    input  logic [31:0] delSharesIn,
    input  logic        delBuySellIn,
    output logic        addValidOut,
    output logic        delExecValidOut,
    output logic [15:0] locateOut,
    output logic [31:0] priceOut,
    output logic [31:0] sharesOut,
    output logic        buySellOut,
    output logic [15:0] mapLocateOut,
    output logic [31:0] mapPriceOut,
    output logic [31:0] mapSharesOut,
    output logic        mapBuySellOut,
`ifdef ORDER_BOOK_SCHED_STATS_EN
    output logic [31:0] issueCntOut,
    output logic [31:0] stallCntOut,
`endif
    output logic        busyOut
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(ISSUE_GAP + 1);

    typedef struct packed {
        logic [15:0] locate;
        logic [31:0] price;
        logic [31:0] shares;
        logic        buy_sell;
    } msg_t;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          last_add_q, last_add_d;
    logic [AW:0]   add_wp_q, add_wp_d, add_rp_q, add_rp_d;
    logic [AW:0]   del_wp_q, del_wp_d, del_rp_q, del_rp_d;
    msg_t          add_mem_q [FIFO_DEPTH];
    msg_t          del_mem_q [FIFO_DEPTH];
    msg_t          add_out_q, add_out_d, del_out_q, del_out_d;
    logic          add_stb_q, add_stb_d, del_stb_q, del_stb_d;
    logic          add_empty, add_full, del_empty, del_full;
    logic          add_push, del_push, go, grant_add;

    // The grant is taken and the head popped on the edge leaving IDLE, so the strobe
    // and its payload are registered and appear during the single ISSUE cycle.
    // IDLE and ISSUE each take one cycle, so GAP lasts ISSUE_GAP-2 cycles to make
    // strobes exactly ISSUE_GAP apart; with ISSUE_GAP==2 ISSUE returns straight to IDLE.
    always_comb begin
        add_empty  = add_wp_q == add_rp_q;
        del_empty  = del_wp_q == del_rp_q;
        add_full   = (add_wp_q[AW] != add_rp_q[AW]) && (add_wp_q[AW-1:0] == add_rp_q[AW-1:0]);
        del_full   = (del_wp_q[AW] != del_rp_q[AW]) && (del_wp_q[AW-1:0] == del_rp_q[AW-1:0]);
        add_push   = addValidIn && !add_full;
        del_push   = delValidIn && !del_full;
        go         = (state_q == IDLE) && !(add_empty && del_empty);
        grant_add  = !add_empty && (del_empty || !last_add_q);
        add_stb_d  = go && grant_add;
        del_stb_d  = go && !grant_add;
        add_wp_d   = add_wp_q + (AW+1)'(add_push);
        del_wp_d   = del_wp_q + (AW+1)'(del_push);
        add_rp_d   = add_rp_q + (AW+1)'(add_stb_d);
        del_rp_d   = del_rp_q + (AW+1)'(del_stb_d);
        add_out_d  = add_stb_d ? add_mem_q[add_rp_q[AW-1:0]] : add_out_q;
        del_out_d  = del_stb_d ? del_mem_q[del_rp_q[AW-1:0]] : del_out_q;
        last_add_d = go ? grant_add : last_add_q;
        gap_cnt_d  = (state_q == GAP) ? gap_cnt_q + 1'b1 : '0;
        state_d    = go ? ISSUE :
                     (state_q == ISSUE) ? ((ISSUE_GAP > 2) ? GAP : IDLE) :
                     ((state_q == GAP) && (gap_cnt_q == GW'(ISSUE_GAP - 3))) ? IDLE : state_q;
    end

    always_ff @(posedge clkIn) begin
        if (!rstNIn) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            last_add_q <= 1'b0;
            add_wp_q   <= '0;
            add_rp_q   <= '0;
            del_wp_q   <= '0;
            del_rp_q   <= '0;
            add_out_q  <= '0;
            del_out_q  <= '0;
            add_stb_q  <= 1'b0;
            del_stb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            last_add_q <= last_add_d;
            add_wp_q   <= add_wp_d;
            add_rp_q   <= add_rp_d;
            del_wp_q   <= del_wp_d;
            del_rp_q   <= del_rp_d;
            add_out_q  <= add_out_d;
            del_out_q  <= del_out_d;
            add_stb_q  <= add_stb_d;
            del_stb_q  <= del_stb_d;
        end
        if (add_push) add_mem_q[add_wp_q[AW-1:0]] <= {addLocateIn, addPriceIn, addSharesIn, addBuySellIn};
        if (del_push) del_mem_q[del_wp_q[AW-1:0]] <= {delLocateIn, delPriceIn, delSharesIn, delBuySellIn};
    end

    assign addReadyOut     = !add_full;
    assign delReadyOut     = !del_full;
    assign busyOut         = (state_q != IDLE) || !add_empty || !del_empty;
    assign addValidOut     = add_stb_q;
    assign delExecValidOut = del_stb_q;
    assign {locateOut, priceOut, sharesOut, buySellOut}             = add_out_q;
    assign {mapLocateOut, mapPriceOut, mapSharesOut, mapBuySellOut} = del_out_q;

`ifdef ORDER_BOOK_SCHED_STATS_EN
    logic [31:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

    // A stall cycle counts once even if both requesters are blocked.
    always_comb begin
        issue_cnt_d = issue_cnt_q + 32'(go);
        stall_cnt_d = stall_cnt_q + 32'((addValidIn && add_full) || (delValidIn && del_full));
    end

    always_ff @(posedge clkIn) begin
        if (!rstNIn) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issueCntOut = issue_cnt_q;
    assign stallCntOut = stall_cnt_q;
`endif
endmodule

// File: tb/tb_order_book_sched.sv
// tb_order_book_sched: scoreboard bench for order_book_sched against a queue-level reference model.
module tb_order_book_sched;
    localparam int DEPTH = 4;
    localparam int GAP   = 4;

    typedef struct packed {
        logic [15:0] loc;
        logic [31:0] price;
        logic [31:0] shares;
        logic        bs;
    } msg_t;

    typedef struct packed {
        logic is_add;
        msg_t m;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        add_valid = 1'b0, del_valid = 1'b0;
    msg_t        add_p = '0, del_p = '0;
    logic        add_ready, del_ready, add_v_o, del_v_o, busy;
    logic [15:0] loc_o, mloc_o;
    logic [31:0] price_o, shares_o, mprice_o, mshares_o;
    logic        bs_o, mbs_o;
`ifdef ORDER_BOOK_SCHED_STATS_EN
    logic [31:0] issue_cnt_o, stall_cnt_o;
`endif

    always #5 clk = ~clk;

    order_book_sched #(.FIFO_DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
        .clkIn(clk), .rstNIn(rst_n),
        .addValidIn(add_valid), .addReadyOut(add_ready),
        .addLocateIn(add_p.loc), .addPriceIn(add_p.price),
        .addSharesIn(add_p.shares), .addBuySellIn(add_p.bs),
        .delValidIn(del_valid), .delReadyOut(del_ready),
        .delLocateIn(del_p.loc), .delPriceIn(del_p.price),
        .delSharesIn(del_p.shares), .delBuySellIn(del_p.bs),
        .addValidOut(add_v_o), .delExecValidOut(del_v_o),
        .locateOut(loc_o), .priceOut(price_o), .sharesOut(shares_o), .buySellOut(bs_o),
        .mapLocateOut(mloc_o), .mapPriceOut(mprice_o), .mapSharesOut(mshares_o), .mapBuySellOut(mbs_o),
`ifdef ORDER_BOOK_SCHED_STATS_EN
        .issueCntOut(issue_cnt_o), .stallCntOut(stall_cnt_o),
`endif
        .busyOut(busy)
    );

    // Reference model state: pending stimulus, the two request queues, the
    // expected strobe stream and the minimum-spacing cooldown between issues.
    msg_t pa[$], pd[$], aq[$], dq[$];
    ev_t  exp_q[$];
    int   cool = 0;
    logic last_add = 1'b0;
    msg_t hold_a = '0, hold_d = '0;
    int   issues = 0, stalls = 0;
    bit   throttle = 1'b0;
    int   n_chk = 0, n_fail = 0;

    task automatic chk(string nm, logic [80:0] act, logic [80:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic msg_t rand_msg();
        msg_t m;
        m.loc    = 16'($urandom);
        m.price  = $urandom;
        m.shares = $urandom;
        m.bs     = 1'($urandom);
        return m;
    endfunction

    // Model: once the spacing since the last issue allows, grant the only
    // non-empty queue, or alternate when both hold entries. Fullness is judged
    // before this edge's pop, so a push into a full queue is refused.
    always @(posedge clk) begin : model
        bit af, df, ga;
        if (!rst_n) begin
            aq.delete(); dq.delete(); exp_q.delete();
            cool = 0; last_add = 1'b0; hold_a = '0; hold_d = '0;
            issues = 0; stalls = 0;
        end else begin
            af = aq.size() == DEPTH;
            df = dq.size() == DEPTH;
            if ((add_valid && af) || (del_valid && df)) stalls++;
            if (cool == 0 && (aq.size() > 0 || dq.size() > 0)) begin
                ga = aq.size() > 0 && (dq.size() == 0 || !last_add);
                if (ga) begin
                    hold_a = aq.pop_front();
                    exp_q.push_back({1'b1, hold_a});
                end else begin
                    hold_d = dq.pop_front();
                    exp_q.push_back({1'b0, hold_d});
                end
                last_add = ga;
                cool = GAP - 1;
                issues++;
            end else if (cool > 0) cool--;
            if (add_valid && !af) aq.push_back(pa.pop_front());
            if (del_valid && !df) dq.push_back(pd.pop_front());
        end
    end

    always @(negedge clk) begin : monitor
        ev_t e;
        if (add_v_o || del_v_o) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL strobe: unexpected add=%0b del=%0b at %0t", add_v_o, del_v_o, $time);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_add", 81'(add_v_o), 81'(e.is_add));
                chk("strobe_del", 81'(del_v_o), 81'(!e.is_add));
                chk("payload", e.is_add ? {loc_o, price_o, shares_o, bs_o}
                                        : {mloc_o, mprice_o, mshares_o, mbs_o}, e.m);
            end
        end else if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL strobe: missing, %0d expected at %0t", exp_q.size(), $time);
            exp_q.delete();
        end
        chk("add_fields", {loc_o, price_o, shares_o, bs_o}, hold_a);
        chk("del_fields", {mloc_o, mprice_o, mshares_o, mbs_o}, hold_d);
        chk("add_ready", 81'(add_ready), 81'(aq.size() < DEPTH));
        chk("del_ready", 81'(del_ready), 81'(dq.size() < DEPTH));
        chk("busy", 81'(busy), 81'(cool > 0 || aq.size() > 0 || dq.size() > 0));
`ifdef ORDER_BOOK_SCHED_STATS_EN
        chk("issue_cnt", 81'(issue_cnt_o), 81'(issues));
        chk("stall_cnt", 81'(stall_cnt_o), 81'(stalls));
`endif
    end

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            add_valid = rst_n && pa.size() > 0 && (!throttle || $urandom_range(1) == 1);
            del_valid = rst_n && pd.size() > 0 && (!throttle || $urandom_range(1) == 1);
            add_p = pa.size() > 0 ? pa[0] : '0;
            del_p = pd.size() > 0 ? pd[0] : '0;
        end
    endtask

    task automatic wait_idle(int max_cyc);
        int n = 0;
        while ((pa.size() + pd.size() + aq.size() + dq.size() > 0 || cool > 0) && n < max_cyc) begin
            step(1);
            n++;
        end
        if (n >= max_cyc) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
        end
        step(2);
    endtask

    task automatic do_reset();
        pa.delete(); pd.delete();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        msg_t m;
        step(3);
        rst_n = 1'b1;
        step(2);
        m.loc = 16'h0001; m.price = 32'h64; m.shares = 32'd10; m.bs = 1'b1;
        pa.push_back(m);
        wait_idle(30);
        pa.push_back(rand_msg());
        pd.push_back(rand_msg());
        wait_idle(40);
        repeat (5) pa.push_back(rand_msg());
        wait_idle(80);
        repeat (3) begin
            pa.push_back(rand_msg());
            pd.push_back(rand_msg());
        end
        wait_idle(80);
        repeat (3) pa.push_back(rand_msg());
        step(3);
        do_reset();
        step(10);
        throttle = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (pa.size() < 3 && $urandom_range(2) == 0) pa.push_back(rand_msg());
            if (pd.size() < 3 && $urandom_range(2) == 0) pd.push_back(rand_msg());
            if ($urandom_range(499) == 0) do_reset();
            step(1);
        end
        throttle = 1'b0;
        wait_idle(200);
        chk("scoreboard_empty", 81'(exp_q.size()), 81'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
